tft_rx_monitor: RTL and testbench

Receive-side counterpart of the TFT timing controller: it samples the panel-side stream (hsync, vsync, tft_de, rgb_tft) in the 9 MHz pixel domain and recovers pixel coordinates, a per-pixel valid strobe and per-frame geometry and integrity results. It sits on the TFT output bus in simulation benches and in on-chip self-test of the snake display path, so a frame drawn by the renderer can be checked pixel by pixel, line by line and frame by frame.

---
 rtl/tft_rx_monitor_pkg.sv | 18 +
 rtl/tft_edge_det.sv | 20 ++
 rtl/tft_rx_monitor.sv | 175 +++++++++++++++++
 tb/tb_tft_rx_monitor.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/tft_rx_monitor_pkg.sv
// Panel timing constants shared with the TFT timing controller, plus monitor FSM encodings.
package tft_rx_monitor_pkg;

  localparam int TFT_H_SYNC  = 41;
  localparam int TFT_H_BACK  = 2;
  localparam int TFT_H_VALID = 480;
  localparam int TFT_H_FRONT = 2;
  localparam int TFT_V_SYNC  = 10;
  localparam int TFT_V_BACK  = 2;
  localparam int TFT_V_VALID = 272;
  localparam int TFT_V_FRONT = 2;

  localparam int CNT_W = 10;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_SYNCED = 1'b1;

endpackage

// File: rtl/tft_edge_det.sv
// Registered rise/fall detector: compares the incoming (already registered) level with a one-cycle-delayed copy.
module tft_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sig_q <= 1'b0;
    else       sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;
  assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/tft_rx_monitor.sv
// TFT receive-side monitor: recovers pixel coordinates from the panel stream and scores each frame.
// de overlapping an hsync pulse is treated as a sync violation, like de during vsync.
module tft_rx_monitor
  import tft_rx_monitor_pkg::*;
#(
  parameter int H_VALID = TFT_H_VALID,
  parameter int V_VALID = TFT_V_VALID
) (
  input  logic        tft_clk_9m,
  input  logic        sys_rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        tft_de,
  input  logic [15:0] rgb_tft,
  output logic        pix_valid,
  output logic [9:0]  rx_x,
  output logic [9:0]  rx_y,
  output logic [15:0] rx_data,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [9:0]  lines_seen,
  output logic [31:0] frame_sum,
  output logic [7:0]  bad_frames
);

  localparam logic [CNT_W-1:0] H_CNT = CNT_W'(H_VALID);
  localparam logic [CNT_W-1:0] V_CNT = CNT_W'(V_VALID);

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [7:0] sat_inc_bad(input logic [7:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic              hs_p0_q, vs_p0_q, de_p0_q;
  logic [15:0]       rgb_p0_q;
  logic              de_fall, vs_rise, de_rise_nc, vs_fall_nc;

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  x_q, x_d, y_q, y_d;
  logic [31:0]       acc_q, acc_d;
  logic              line_err_q, line_err_d, sync_err_q, sync_err_d;

  logic              vld_p1_q, vld_p1_d;
  logic [CNT_W-1:0]  rx_x_q, rx_x_d, rx_y_q, rx_y_d;
  logic [15:0]       rx_data_q, rx_data_d;
  logic              done_q, done_d, ok_q, ok_d;
  logic [CNT_W-1:0]  lines_q, lines_d;
  logic [31:0]       sum_q, sum_d;
  logic [7:0]        bad_q, bad_d;

  tft_edge_det u_de_edge (
    .clk_i (tft_clk_9m), .rst_i (sys_rst), .sig_i (de_p0_q),
    .rise_o(de_rise_nc), .fall_o(de_fall)
  );

  tft_edge_det u_vs_edge (
    .clk_i (tft_clk_9m), .rst_i (sys_rst), .sig_i (vs_p0_q),
    .rise_o(vs_rise), .fall_o(vs_fall_nc)
  );

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    acc_d      = acc_q;
    line_err_d = line_err_q;
    sync_err_d = sync_err_q;
    vld_p1_d   = 1'b0;
    rx_x_d     = rx_x_q;
    rx_y_d     = rx_y_q;
    rx_data_d  = rx_data_q;
    done_d     = 1'b0;
    ok_d       = ok_q;
    lines_d    = lines_q;
    sum_d      = sum_q;
    bad_d      = bad_q;
    if (state_q == ST_IDLE) begin
      if (vs_rise) begin
        state_d    = ST_SYNCED;
        x_d        = '0;
        y_d        = '0;
        acc_d      = '0;
        line_err_d = 1'b0;
        sync_err_d = 1'b0;
      end
    end else begin
      if (de_p0_q) begin
        vld_p1_d  = 1'b1;
        rx_x_d    = x_q;
        rx_y_d    = y_q;
        rx_data_d = rgb_p0_q;
        x_d       = sat_inc_cnt(x_q);
        acc_d     = acc_q + {16'd0, rgb_p0_q};
        if (vs_p0_q || hs_p0_q) sync_err_d = 1'b1;
      end
      if (de_fall) begin
        if (x_q != H_CNT) line_err_d = 1'b1;
        y_d = sat_inc_cnt(y_q);
        x_d = '0;
      end
      // Frame close uses the _d values so a same-cycle pixel counts toward the ending frame.
      if (vs_rise) begin
        done_d     = 1'b1;
        ok_d       = !line_err_d && !sync_err_d && (y_d == V_CNT);
        lines_d    = y_d;
        sum_d      = acc_d;
        bad_d      = ok_d ? bad_q : sat_inc_bad(bad_q);
        x_d        = '0;
        y_d        = '0;
        acc_d      = '0;
        line_err_d = 1'b0;
        sync_err_d = 1'b0;
      end
    end
  end

  // Stage p0: input register; stage p1: counters and output register.
  always_ff @(posedge tft_clk_9m or posedge sys_rst) begin
    if (sys_rst) begin
      hs_p0_q    <= 1'b0;
      vs_p0_q    <= 1'b0;
      de_p0_q    <= 1'b0;
      rgb_p0_q   <= '0;
      state_q    <= ST_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      acc_q      <= '0;
      line_err_q <= 1'b0;
      sync_err_q <= 1'b0;
      vld_p1_q   <= 1'b0;
      rx_x_q     <= '0;
      rx_y_q     <= '0;
      rx_data_q  <= '0;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
      lines_q    <= '0;
      sum_q      <= '0;
      bad_q      <= '0;
    end else begin
      hs_p0_q    <= hsync;
      vs_p0_q    <= vsync;
      de_p0_q    <= tft_de;
      rgb_p0_q   <= rgb_tft;
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      acc_q      <= acc_d;
      line_err_q <= line_err_d;
      sync_err_q <= sync_err_d;
      vld_p1_q   <= vld_p1_d;
      rx_x_q     <= rx_x_d;
      rx_y_q     <= rx_y_d;
      rx_data_q  <= rx_data_d;
      done_q     <= done_d;
      ok_q       <= ok_d;
      lines_q    <= lines_d;
      sum_q      <= sum_d;
      bad_q      <= bad_d;
    end
  end

  assign pix_valid  = vld_p1_q;
  assign rx_x       = rx_x_q;
  assign rx_y       = rx_y_q;
  assign rx_data    = rx_data_q;
  assign frame_done = done_q;
  assign frame_ok   = ok_q;
  assign lines_seen = lines_q;
  assign frame_sum  = sum_q;
  assign bad_frames = bad_q;

endmodule

// File: tb/tb_tft_rx_monitor.sv
// Scoreboard bench for tft_rx_monitor using a reduced 8x6 panel geometry.
module tb_tft_rx_monitor;

  localparam int HV = 8;
  localparam int VV = 6;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] d;
  } pix_t;

  typedef struct packed {
    logic        ok;
    logic [9:0]  lines;
    logic [31:0] sum;
    logic [7:0]  bad;
  } frm_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hs = 1'b0, vs = 1'b0, de = 1'b0;
  logic [15:0] rgb = '0;
  logic        pix_valid, frame_done, frame_ok;
  logic [9:0]  rx_x, rx_y, lines_seen;
  logic [15:0] rx_data;
  logic [31:0] frame_sum;
  logic [7:0]  bad_frames;

  pix_t pix_q[$];
  frm_t frm_q[$];

  int          checks = 0;
  int          fails  = 0;
  bit          synced_m = 1'b0;
  int          x_m = 0, y_m = 0;
  logic [31:0] sum_m = '0;
  logic        done_prev = 1'b0;

  tft_rx_monitor #(.H_VALID(HV), .V_VALID(VV)) dut (
    .tft_clk_9m(clk), .sys_rst(rst), .hsync(hs), .vsync(vs), .tft_de(de), .rgb_tft(rgb),
    .pix_valid(pix_valid), .rx_x(rx_x), .rx_y(rx_y), .rx_data(rx_data),
    .frame_done(frame_done), .frame_ok(frame_ok), .lines_seen(lines_seen),
    .frame_sum(frame_sum), .bad_frames(bad_frames)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pix(input logic [15:0] d);
    logic [9:0] xs, ys;
    xs = x_m[9:0];
    ys = y_m[9:0];
    de  = 1'b1;
    rgb = d;
    if (synced_m) begin
      pix_q.push_back(pix_t'{xs, ys, d});
      sum_m = sum_m + {16'd0, d};
    end
    x_m++;
    tick();
  endtask

  // pat 0: all-ones, 1: coordinate ramp, 2: random
  task automatic send_line(input int n, input int pat);
    logic [9:0] xv, yv;
    logic [15:0] d;
    hs = 1'b1; tick();
    hs = 1'b0; tick();
    for (int i = 0; i < n; i++) begin
      xv = x_m[9:0];
      yv = y_m[9:0];
      case (pat)
        0:       d = 16'hFFFF;
        1:       d = {yv[5:0], 5'd0, xv[4:0]};
        default: d = 16'($urandom);
      endcase
      drive_pix(d);
    end
    de = 1'b0;
    y_m++;
    x_m = 0;
    tick(); tick();
  endtask

  task automatic send_lines(input int nlines, input int pat, input int odd_line, input int odd_len);
    for (int l = 0; l < nlines; l++)
      send_line((l == odd_line) ? odd_len : HV, pat);
  endtask

  task automatic end_frame(input bit exp_ok, input int exp_lines, input int exp_bad, input bit stray);
    logic [9:0] el;
    logic [7:0] eb;
    el = exp_lines[9:0];
    eb = exp_bad[7:0];
    vs = 1'b1;
    if (synced_m) frm_q.push_back(frm_t'{exp_ok, el, sum_m, eb});
    synced_m = 1'b1;
    sum_m = '0;
    x_m = 0;
    y_m = 0;
    tick();
    if (stray) begin
      drive_pix(16'h1234);
      de = 1'b0;
      y_m++;
      x_m = 0;
    end else begin
      tick();
    end
    tick();
    vs = 1'b0;
    tick(); tick();
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (pix_valid) begin
        if (pix_q.size() == 0) begin
          check("pix_unexpected", 32'(pix_valid), 32'd0);
        end else begin
          pix_t e;
          e = pix_q.pop_front();
          check("rx_x", 32'(rx_x), 32'(e.x));
          check("rx_y", 32'(rx_y), 32'(e.y));
          check("rx_data", 32'(rx_data), 32'(e.d));
        end
      end
      if (frame_done) begin
        check("frame_done_width", 32'(done_prev), 32'd0);
        if (frm_q.size() == 0) begin
          check("frame_done_unexpected", 32'(frame_done), 32'd0);
        end else begin
          frm_t f;
          f = frm_q.pop_front();
          check("frame_ok", 32'(frame_ok), 32'(f.ok));
          check("lines_seen", 32'(lines_seen), 32'(f.lines));
          check("frame_sum", frame_sum, f.sum);
          check("bad_frames", 32'(bad_frames), 32'(f.bad));
        end
      end
      done_prev = frame_done;
    end else begin
      done_prev = 1'b0;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    check({tag, "_rx_x"}, 32'(rx_x), 32'd0);
    check({tag, "_rx_y"}, 32'(rx_y), 32'd0);
    check({tag, "_rx_data"}, 32'(rx_data), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_frame_ok"}, 32'(frame_ok), 32'd0);
    check({tag, "_lines_seen"}, 32'(lines_seen), 32'd0);
    check({tag, "_frame_sum"}, frame_sum, 32'd0);
    check({tag, "_bad_frames"}, 32'(bad_frames), 32'd0);
  endtask

  initial begin
    int eb;
    tick(); tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    send_line(HV, 0);            // ignored while unsynchronised
    end_frame(1'b0, 0, 0, 1'b0); // first vsync only syncs

    send_lines(VV, 0, -1, 0);
    end_frame(1'b1, 6, 0, 1'b0);
    send_lines(VV, 1, -1, 0);
    end_frame(1'b1, 6, 0, 1'b0);
    send_lines(VV, 2, 2, HV - 1);
    end_frame(1'b0, 6, 1, 1'b0);
    send_lines(VV, 2, -1, 0);
    end_frame(1'b1, 6, 1, 1'b0);
    send_lines(VV - 2, 2, -1, 0);
    end_frame(1'b0, 4, 2, 1'b1); // stray de lands in the next frame
    send_lines(VV, 2, -1, 0);
    end_frame(1'b0, 7, 3, 1'b0);
    send_lines(VV, 2, 5, HV + 1);
    end_frame(1'b0, 6, 4, 1'b0);

    for (int i = 0; i < 255; i++) begin
      eb = (5 + i > 255) ? 255 : 5 + i;
      end_frame(1'b0, 0, eb, 1'b0);
    end
    send_lines(VV, 0, -1, 0);
    end_frame(1'b1, 6, 255, 1'b0);

    send_lines(3, 2, -1, 0);
    repeat (4) tick();
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("midrst");
    check("midrst_pix_q_empty", 32'(pix_q.size()), 32'd0);
    check("midrst_frm_q_empty", 32'(frm_q.size()), 32'd0);
    synced_m = 1'b0;
    sum_m = '0;
    x_m = 0;
    y_m = 0;
    tick(); tick();
    rst = 1'b0;
    tick();

    send_line(HV, 2);
    end_frame(1'b0, 0, 0, 1'b0);
    send_lines(VV, 2, -1, 0);
    end_frame(1'b1, 6, 0, 1'b0);

    for (int i = 0; i < 200 && (pix_q.size() != 0 || frm_q.size() != 0); i++) tick();
    repeat (4) tick();
    check("pix_q_drained", 32'(pix_q.size()), 32'd0);
    check("frm_q_drained", 32'(frm_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
